// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory boot controller.
package imem_pkg;

    localparam int          DEPTH_DEF = 1024;
    localparam int          AW_DEF    = 10;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Host program-load channel: one-cycle start request plus a valid/ready word stream.
interface imem_boot_ctrl_if #(
    parameter int AW = imem_pkg::AW_DEF
) ();
    logic          load_start;
    logic [AW:0]   load_count;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_ready;

    modport master (
        output load_start, load_count, load_valid, load_data,
        input  load_ready
    );

    modport slave (
        input  load_start, load_count, load_valid, load_data,
        output load_ready
    );
endinterface

// File: rtl/imem_load_counter.sv
// Load word counter with latched target; last flags the increment that completes the load.
// Latency: count updates on the edge after inc; last is combinational.
// Backpressure: none, increments only while below target.
module imem_load_counter
    import imem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [AW:0] count_req,
    input  logic        inc,
    output logic [AW:0] count,
    output logic        last
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [AW:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            target <= '0;
        end else if (clear) begin
            count  <= '0;
            target <= (count_req > DEPTH_W) ? DEPTH_W : count_req;
        end else if (inc && (count != target)) begin
            count  <= count + ONE;
        end
    end

    assign last = inc && ((count + ONE) == target);
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader / fetch mux for a single-port IMEM; optional checksum via IMEM_CHECKSUM_EN.
// Latency: writes and fetch reads are zero-cycle; done pulses the first RUN cycle.
// Backpressure: load_ready only in LOAD; fetch stalled outside RUN.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    imem_boot_ctrl_if.slave         load,
    input  logic [31:0]             fetch_pc,
    output logic [31:0]             fetch_instr,
    output logic                    stall,
    output logic                    misalign,
    output logic [AW-1:0]           mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    mem_we,
    input  logic [31:0]             mem_rdata,
    output logic                    done,
    output logic [31:0]             csum
);
    state_t      state, state_nxt;
    logic        start, hs, last, done_nxt;
    logic [AW:0] count;

    // A start request while loading is dropped so the active load is untouched.
    assign start            = load.load_start && (state != LOAD);
    assign load.load_ready  = (state == LOAD);
    assign hs               = load.load_valid && load.load_ready;

    imem_load_counter #(.DEPTH(DEPTH), .AW(AW)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .count_req (load.load_count),
        .inc       (hs),
        .count     (count),
        .last      (last)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    if (load.load_count == '0) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        stall       = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = count[AW-1:0];
        mem_wdata   = load.load_data;
        misalign    = 1'b0;
        fetch_instr = NOP;
        case (state)
            LOAD: mem_we = hs;
            RUN: begin
                stall       = 1'b0;
                mem_addr    = fetch_pc[AW+1:2];
                misalign    = (fetch_pc[1:0] != 2'b00);
                fetch_instr = misalign ? NOP : mem_rdata;
            end
            default: ;
        endcase
    end

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     csum_q <= '0;
        else if (start) csum_q <= '0;
        else if (hs)    csum_q <= csum_q + load.load_data;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{fetch_pc[31:AW+2], count[AW]};
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboarded bench for imem_boot_ctrl: expected writes/done/fetches queued, checked by a negedge monitor.
module tb_imem_boot_ctrl;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    localparam int K_WR = 0, K_DONE = 1, K_FETCH = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
    } ev_t;

    logic          clk, rst_n;
    logic [31:0]   fetch_pc, fetch_instr, mem_wdata, mem_rdata, csum;
    logic          stall, misalign, mem_we, done;
    logic [AW-1:0] mem_addr;
    logic          fetch_probe;

    logic [31:0] mem [0:DEPTH-1];
    ev_t         exp_q[$];
    ev_t         ev;
    int          n_cmp = 0;
    int          n_bad = 0;

    imem_boot_ctrl_if #(.AW(AW)) lif ();

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (lif),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .stall       (stall),
        .misalign    (misalign),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .done        (done),
        .csum        (csum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input logic m);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.mis = m;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) unexpected("write");
            else begin
                ev = exp_q.pop_front();
                check("wr_kind", K_WR, ev.kind);
                check("wr_addr", {22'b0, mem_addr}, ev.addr);
                check("wr_data", mem_wdata, ev.data);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) unexpected("done");
            else begin
                ev = exp_q.pop_front();
                check("done_kind", K_DONE, ev.kind);
            end
        end
        if (fetch_probe) begin
            if (exp_q.size() == 0) unexpected("fetch");
            else begin
                ev = exp_q.pop_front();
                check("fetch_kind", K_FETCH, ev.kind);
                check("fetch_addr", {22'b0, mem_addr}, ev.addr);
                check("fetch_instr", fetch_instr, ev.data);
                check("fetch_misalign", {31'b0, misalign}, {31'b0, ev.mis});
                check("fetch_stall", {31'b0, stall}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] n);
        lif.load_start = 1'b1;
        lif.load_count = n;
        tick();
        lif.load_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d, input logic m);
        push(K_FETCH, a, d, m);
        fetch_pc    = pc;
        fetch_probe = 1'b1;
        tick();
        fetch_probe = 1'b0;
    endtask

    logic [31:0] w [0:4];
    logic [31:0] exp_csum;

    initial begin
        w[0] = 32'h02128020; w[1] = 32'h02129022; w[2] = 32'h02729820;
        w[3] = 32'h0272a022; w[4] = 32'h0292a020;
        rst_n = 1'b0; fetch_pc = '0; fetch_probe = 1'b0;
        lif.load_start = 1'b0; lif.load_count = '0; lif.load_valid = 1'b0; lif.load_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, stall}, 32'd1);
        check("rst_ready", {31'b0, lif.load_ready}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_csum", csum, 32'd0);
        check("rst_instr", fetch_instr, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        rst_n = 1'b1;
        // load_valid in IDLE must not write
        lif.load_valid = 1'b1; lif.load_data = 32'hBAD0BAD0;
        tick();
        check("idle_ready", {31'b0, lif.load_ready}, 32'd0);
        lif.load_valid = 1'b0;
        tick();

        // five-word load, valid held through the first RUN cycle
        for (int i = 0; i < 5; i++) push(K_WR, i, w[i], 1'b0);
        push(K_DONE, 0, 0, 1'b0);
        start_load(11'd5);
        check("load_stall", {31'b0, stall}, 32'd1);
        check("load_ready", {31'b0, lif.load_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            lif.load_valid = 1'b1; lif.load_data = w[i];
            tick();
        end
        lif.load_data = 32'hBAD1BAD1;
        check("run_stall", {31'b0, stall}, 32'd0);
        check("run_done", {31'b0, done}, 32'd1);
        tick();
        lif.load_valid = 1'b0;
        check("done_once", {31'b0, done}, 32'd0);

        fetch(32'h8, 2, w[2], 1'b0);
        fetch(32'h1008, 2, w[2], 1'b0);
        fetch(32'h10, 4, w[4], 1'b0);
        fetch(32'h6, 1, 32'h0, 1'b1);

        // reload of 3 with gapped valid and an ignored second start
        push(K_WR, 0, 32'h11111111, 1'b0);
        push(K_WR, 1, 32'h22222222, 1'b0);
        push(K_WR, 2, 32'h33333333, 1'b0);
        push(K_DONE, 0, 0, 1'b0);
        start_load(11'd3);
        check("reload_stall", {31'b0, stall}, 32'd1);
        lif.load_valid = 1'b1; lif.load_data = 32'h11111111; tick();
        lif.load_valid = 1'b0; lif.load_start = 1'b1; lif.load_count = 11'd7; tick();
        lif.load_start = 1'b0;
        lif.load_valid = 1'b1; lif.load_data = 32'h22222222; tick();
        lif.load_valid = 1'b0; tick();
        lif.load_valid = 1'b1; lif.load_data = 32'h33333333; tick();
        lif.load_valid = 1'b0;
        check("reload_run", {31'b0, stall}, 32'd0);
        tick();
        fetch(32'h4, 1, 32'h22222222, 1'b0);
        fetch(32'hC, 3, w[3], 1'b0);

        // zero-length load goes straight to RUN with a done pulse
        push(K_DONE, 0, 0, 1'b0);
        start_load(11'd0);
        check("zero_stall", {31'b0, stall}, 32'd0);
        tick();
        check("zero_done_once", {31'b0, done}, 32'd0);

        // oversize count clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) push(K_WR, i, 32'hA5000000 + i, 1'b0);
        push(K_DONE, 0, 0, 1'b0);
        start_load(11'd2047);
        for (int i = 0; i < DEPTH; i++) begin
            lif.load_valid = 1'b1; lif.load_data = 32'hA5000000 + i;
            tick();
        end
        check("full_stall", {31'b0, stall}, 32'd0);
        lif.load_valid = 1'b0;
        tick();
        fetch(32'hFFC, 1023, 32'hA50003FF, 1'b0);
        fetch(32'h0, 0, 32'hA5000000, 1'b0);

        // reset after two of four words
        push(K_WR, 0, 32'hC0C0C0C0, 1'b0);
        push(K_WR, 1, 32'hC1C1C1C1, 1'b0);
        start_load(11'd4);
        lif.load_valid = 1'b1; lif.load_data = 32'hC0C0C0C0; tick();
        lif.load_data = 32'hC1C1C1C1; tick();
        lif.load_data = 32'hC2C2C2C2;
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", {31'b0, stall}, 32'd1);
        check("arst_ready", {31'b0, lif.load_ready}, 32'd0);
        check("arst_we", {31'b0, mem_we}, 32'd0);
        tick(); tick();
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_csum", csum, 32'd0);
        rst_n = 1'b1; lif.load_valid = 1'b0;
        tick();
        check("arst_idle", {31'b0, stall}, 32'd1);
        check("arst_mem1", mem[1], 32'hC1C1C1C1);
        check("arst_mem2", mem[2], 32'hA5000002);
        check("arst_mem3", mem[3], 32'hA5000003);

        // checksum wraps modulo 2**32
`ifdef IMEM_CHECKSUM_EN
        exp_csum = 32'h00000005;
`else
        exp_csum = 32'h00000000;
`endif
        push(K_WR, 0, 32'h00000001, 1'b0);
        push(K_WR, 1, 32'hFFFFFFFF, 1'b0);
        push(K_WR, 2, 32'h00000005, 1'b0);
        push(K_DONE, 0, 0, 1'b0);
        start_load(11'd3);
        check("csum_clear", csum, 32'd0);
        lif.load_valid = 1'b1; lif.load_data = 32'h00000001; tick();
        lif.load_data = 32'hFFFFFFFF; tick();
        lif.load_data = 32'h00000005; tick();
        lif.load_valid = 1'b0;
        check("csum_done", csum, exp_csum);
        tick(); tick();
        check("csum_hold", csum, exp_csum);
        fetch(32'h8, 2, 32'h00000005, 1'b0);

        tick(); tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
